// File: rtl/rx_frame_fifo.sv
// AXI-Stream frame FIFO between the MAC RX port and the packet parser.
// Define RX_FIFO_STORE_FWD_EN for store-and-forward with bad/overflowed-frame drop; default is cut-through.
module rx_frame_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 2048,
    parameter int AFULL_THRESH = DEPTH - 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    input  logic                     s_tuser,
    output logic                     s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    output logic                     m_tuser,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     frame_drop
);
    // Handshake: a beat transfers on the clk edge where valid & ready are both high;
    // valid and its payload are held unchanged until that edge.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = DATA_W + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    logic [MW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, wr_commit_nxt, rd_ptr_nxt, level_nxt;
    logic          full, wr_en, rd_load, drop_nxt;
    logic [MW-1:0] wr_word;

    // Pointers carry one extra wrap bit so equal low bits can mean either empty or full.
    assign full       = (wr_ptr - rd_ptr) == DEPTH_P;
    assign rd_load    = (wr_commit != rd_ptr) && (!m_tvalid || m_tready);
    assign rd_ptr_nxt = rd_load ? rd_ptr + ONE_P : rd_ptr;
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

`ifdef RX_FIFO_STORE_FWD_EN
    logic ovf, ovf_nxt;

    // The MAC cannot be stalled: beats that find the RAM full poison the rest of their frame.
    assign s_tready = 1'b1;
    assign wr_word  = {1'b0, s_tlast, s_tdata};

    always_comb begin
        wr_en         = 1'b0;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        drop_nxt      = 1'b0;
        ovf_nxt       = ovf;
        if (s_tvalid) begin
            if (s_tlast) begin
                ovf_nxt = 1'b0;
                if (ovf || full || s_tuser) begin
                    wr_ptr_nxt = wr_commit;
                    drop_nxt   = 1'b1;
                end else begin
                    wr_en         = 1'b1;
                    wr_ptr_nxt    = wr_ptr + ONE_P;
                    wr_commit_nxt = wr_ptr + ONE_P;
                end
            end else if (ovf || full) begin
                ovf_nxt = 1'b1;
            end else begin
                wr_en      = 1'b1;
                wr_ptr_nxt = wr_ptr + ONE_P;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf <= 1'b0;
        else        ovf <= ovf_nxt;
    end
`else
    assign s_tready = !full;
    assign wr_word  = {s_tuser & s_tlast, s_tlast, s_tdata};

    always_comb begin
        wr_en         = s_tvalid && !full;
        wr_ptr_nxt    = wr_en ? wr_ptr + ONE_P : wr_ptr;
        wr_commit_nxt = wr_ptr_nxt;
        drop_nxt      = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            wr_commit   <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            frame_drop  <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
            m_tuser     <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            wr_commit   <= wr_commit_nxt;
            rd_ptr      <= rd_ptr_nxt;
            level       <= level_nxt;
            almost_full <= level_nxt >= AFULL_P;
            frame_drop  <= drop_nxt;
            if (rd_load) begin
                m_tvalid                     <= 1'b1;
                {m_tuser, m_tlast, m_tdata}  <= mem[rd_ptr[AW-1:0]];
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

    // RAM has no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_word;
    end
endmodule
